// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA display path: default
// 800x600@72 constants, axis totals and the display_addr packing used by
// the scan driver, the GPU and the mapper.
package vga_timing_pkg;

    localparam int COORD_W = 11;
    localparam int ADDR_W  = 2 * COORD_W;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    // Default 800x600@72 timing, 50 MHz pixel clock
    localparam int H_SYNC_DEF   = 120;
    localparam int H_BACK_DEF   = 64;
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FRONT_DEF  = 56;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BACK_DEF   = 23;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FRONT_DEF  = 37;

    // Per-position flags carried down the output pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic first;
    } scan_flags_t;

    function automatic int h_tot(int sync, int back, int active, int front);
        return sync + back + active + front;
    endfunction

    function automatic int v_tot(int sync, int back, int active, int front);
        return sync + back + active + front;
    endfunction

    // display_addr layout: {h[10:0], v[10:0]}
    function automatic addr_t pack_addr(coord_t h, coord_t v);
        return {h, v};
    endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// Display fetch bus between the scan driver (address issuer, data consumer)
// and the GPU (answers the requested raster position).
interface vga_scan_driver_if;
    import vga_timing_pkg::*;

    addr_t       display_addr;
    logic [2:0]  display_data;

    modport master (output display_addr, input display_data);
    modport slave  (input display_addr, output display_data);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter ordered sync, back porch,
// active, front porch, with decoded sync/active flags for the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BACK   = H_BACK_DEF,
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FRONT  = H_FRONT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output logic   wrap,
    output coord_t cnt,
    output logic   sync,
    output logic   active
);

    localparam int     TOT      = h_tot(SYNC, BACK, ACTIVE, FRONT);
    localparam coord_t LAST     = coord_t'(TOT - 1);
    localparam coord_t SYNC_END = coord_t'(SYNC);
    localparam coord_t ACT_BEG  = coord_t'(SYNC + BACK);
    localparam coord_t ACT_END  = coord_t'(SYNC + BACK + ACTIVE);

    coord_t cnt_q, cnt_d;

    // wrap is the terminal count of an enabled step; it enables the next axis
    assign wrap = en && (cnt_q == LAST);

    // next count: reset to 0, wrap at the end of the axis, else step when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (rst)
            cnt_d = '0;
        else if (wrap)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    // count register
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt    = cnt_q;
    assign sync   = (cnt_q < SYNC_END);
    assign active = (cnt_q >= ACT_BEG) && (cnt_q < ACT_END);

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster timing generator and pin stage. Issues the raster position as
// display_addr, then after PIPE_DELAY cycles drives RGB/sync/status pins
// for that same position, with the GPU's pixel captured on the last stage.
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int PIPE_DELAY = 1
) (
    input  logic               sysclk,
    input  logic               reset,
    vga_scan_driver_if.master  disp,
    output logic [2:0]         vga_rgb,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               frame_start,
    output logic               active
);

    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
        $error("vga_scan_driver: PIPE_DELAY must be in 1..4");
    end

    coord_t h_cnt, v_cnt;
    logic   h_wrap, h_sync, h_act;
    logic   v_wrap_unused, v_sync, v_act;

    vga_axis_counter #(
        .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)
    ) u_h_axis (
        .clk(sysclk), .rst(reset), .en(1'b1),
        .wrap(h_wrap), .cnt(h_cnt), .sync(h_sync), .active(h_act)
    );

    // vertical axis steps once per horizontal wrap
    vga_axis_counter #(
        .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)
    ) u_v_axis (
        .clk(sysclk), .rst(reset), .en(h_wrap),
        .wrap(v_wrap_unused), .cnt(v_cnt), .sync(v_sync), .active(v_act)
    );

    assign disp.display_addr = pack_addr(h_cnt, v_cnt);

    // chain[0] is the position currently on display_addr; chain[k] is the
    // position issued k cycles ago. chain[PIPE_DELAY] is what the pins show.
    scan_flags_t                  cur_flags;
    scan_flags_t [PIPE_DELAY-1:0] pipe_q, pipe_d;
    scan_flags_t [PIPE_DELAY:0]   chain;
    scan_flags_t                  feed_flags, out_flags;
    logic [2:0]                   rgb_q, rgb_d;

    assign cur_flags = '{hs:    h_sync,
                         vs:    v_sync,
                         act:   h_act && v_act,
                         first: (h_cnt == '0) && (v_cnt == '0)};

    assign chain      = {pipe_q, cur_flags};
    assign feed_flags = chain[PIPE_DELAY-1];
    assign out_flags  = chain[PIPE_DELAY];

    // shift the flags one stage and capture the pixel into the final stage;
    // reset flushes every stage so no partial pixel follows a reset
    always_comb begin
        pipe_d = chain[PIPE_DELAY-1:0];
        rgb_d  = feed_flags.act ? disp.display_data : 3'b000;
        if (reset) begin
            pipe_d = '0;
            rgb_d  = 3'b000;
        end
    end

    // pipeline and pixel registers
    always_ff @(posedge sysclk) begin
        pipe_q <= pipe_d;
        rgb_q  <= rgb_d;
    end

    assign vga_rgb     = rgb_q;
    assign vga_hsync   = out_flags.hs ? HS_POL : ~HS_POL;
    assign vga_vsync   = out_flags.vs ? VS_POL : ~VS_POL;
    assign active      = out_flags.act;
    assign frame_start = out_flags.first;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: three instances share one clock.
//   A: default timing, PIPE_DELAY=1, constant pixel 3'b101
//   B: default timing, PIPE_DELAY=3, GPU returns h[2:0] two cycles late
//   C: tiny timing (12x7), PIPE_DELAY=2, negative syncs, constant 3'b110
// A bench raster model feeds a per-instance expectation queue; probe table
// and hand sequences cover the corners.
module tb_vga_scan_driver;
    import vga_timing_pkg::*;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic [2:0] rst = 3'b111;

    vga_scan_driver_if ifA ();
    vga_scan_driver_if ifB ();
    vga_scan_driver_if ifC ();

    logic [2:0] rgbA, rgbB, rgbC;
    logic hsA, vsA, fsA, actA, hsB, vsB, fsB, actB, hsC, vsC, fsC, actC;

    // GPU stand-ins
    logic [2:0] gpu_d1, gpu_d2;
    always @(posedge sysclk) begin
        gpu_d1 <= ifB.display_addr[13:11];
        gpu_d2 <= gpu_d1;
    end
    assign ifA.display_data = 3'b101;
    assign ifB.display_data = gpu_d2;
    assign ifC.display_data = 3'b110;

    vga_scan_driver u_a (
        .sysclk(sysclk), .reset(rst[0]), .disp(ifA), .vga_rgb(rgbA),
        .vga_hsync(hsA), .vga_vsync(vsA), .frame_start(fsA), .active(actA));

    vga_scan_driver #(.PIPE_DELAY(3)) u_b (
        .sysclk(sysclk), .reset(rst[1]), .disp(ifB), .vga_rgb(rgbB),
        .vga_hsync(hsB), .vga_vsync(vsB), .frame_start(fsB), .active(actB));

    vga_scan_driver #(
        .H_SYNC(3), .H_BACK(2), .H_ACTIVE(5), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(2)
    ) u_c (
        .sysclk(sysclk), .reset(rst[2]), .disp(ifC), .vga_rgb(rgbC),
        .vga_hsync(hsC), .vga_vsync(vsC), .frame_start(fsC), .active(actC));

    // bench-side timing of the three instances
    int HS[3] = '{120, 120, 3};
    int HB[3] = '{64, 64, 2};
    int HA[3] = '{800, 800, 5};
    int HF[3] = '{56, 56, 2};
    int VS[3] = '{6, 6, 2};
    int VB[3] = '{23, 23, 1};
    int VA[3] = '{600, 600, 3};
    int VF[3] = '{37, 37, 1};
    bit HP[3] = '{1'b1, 1'b1, 1'b0};
    bit VP[3] = '{1'b1, 1'b1, 1'b0};
    int PD[3] = '{1, 3, 2};

    // pins packed as {rgb[2:0], hsync, vsync, frame_start, active}
    typedef struct { int h; int v; logic [6:0] pins; } exp_t;
    typedef struct { int h; int v; logic [6:0] pins; } probe_t;

    exp_t   qA[$], qB[$], qC[$];
    probe_t probes[12];
    int     mh[3], mv[3];
    int     checks = 0, failures = 0, cyc = 0;
    int     hits = 0, hs29 = 0, n101 = 0, first101 = -1, last101 = -1, nz28 = 0;
    int     lastC = -1, vslowC = 0, framesC = 0;

    task automatic check(input string dut, input string what,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s.%s cycle %0d: got 0x%0h expected 0x%0h",
                         dut, what, cyc, got, exp);
        end
    endtask

    function automatic int htot(int k);
        return HS[k] + HB[k] + HA[k] + HF[k];
    endfunction

    function automatic int vtot(int k);
        return VS[k] + VB[k] + VA[k] + VF[k];
    endfunction

    function automatic exp_t model_pins(int k, int h, int v);
        exp_t e;
        bit ha, va, act;
        logic [2:0] px;
        ha  = (h >= HS[k] + HB[k]) && (h < HS[k] + HB[k] + HA[k]);
        va  = (v >= VS[k] + VB[k]) && (v < VS[k] + VB[k] + VA[k]);
        act = ha && va;
        case (k)
            0: px = 3'b101;
            1: px = 3'(h);
            default: px = 3'b110;
        endcase
        e.h = h;
        e.v = v;
        e.pins = {act ? px : 3'b000,
                  (h < HS[k]) ? HP[k] : !HP[k],
                  (v < VS[k]) ? VP[k] : !VP[k],
                  (h == 0 && v == 0), act};
        return e;
    endfunction

    function automatic exp_t idle_exp(int k);
        exp_t e;
        e.h = -1;
        e.v = -1;
        e.pins = {3'b000, !HP[k], !VP[k], 1'b0, 1'b0};
        return e;
    endfunction

    function automatic logic [6:0] dut_pins(int k);
        case (k)
            0: return {rgbA, hsA, vsA, fsA, actA};
            1: return {rgbB, hsB, vsB, fsB, actB};
            default: return {rgbC, hsC, vsC, fsC, actC};
        endcase
    endfunction

    function automatic addr_t dut_addr(int k);
        case (k)
            0: return ifA.display_addr;
            1: return ifB.display_addr;
            default: return ifC.display_addr;
        endcase
    endfunction

    // A-only bookkeeping on each popped expectation
    task automatic probe_a(input exp_t e, input logic [6:0] got);
        if (e.v == 29) begin
            hs29 += int'(got[3]);
            if (got[6:4] == 3'b101) begin
                n101++;
                if (first101 < 0) first101 = e.h;
                last101 = e.h;
            end
        end
        if (e.v == 28 && got[6:4] != 3'b000) nz28++;
        for (int i = 0; i < 12; i++)
            if (probes[i].h == e.h && probes[i].v == e.v) begin
                check("A", "probe", 32'(got), 32'(probes[i].pins));
                hits++;
            end
    endtask

    // C frame bookkeeping: period and vsync-asserted cycles per frame
    task automatic frame_c(input logic [6:0] got);
        if (got[1]) begin
            if (lastC >= 0) begin
                check("C", "frame_period", 32'(cyc - lastC), 32'd84);
                check("C", "vsync_cycles", 32'(vslowC), 32'd24);
                framesC++;
            end
            lastC  = cyc;
            vslowC = 0;
        end
        if (!got[2]) vslowC++;
    endtask

    // one clock: advance the model at the edge, compare away from it
    task automatic tick();
        exp_t e;
        logic [6:0] got;
        @(posedge sysclk);
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                mh[k] = 0;
                mv[k] = 0;
            end else if (mh[k] == htot(k) - 1) begin
                mh[k] = 0;
                mv[k] = (mv[k] == vtot(k) - 1) ? 0 : mv[k] + 1;
            end else begin
                mh[k]++;
            end
        end
        if (rst[0]) begin qA.delete(); repeat (PD[0]) qA.push_back(idle_exp(0)); end
        if (rst[1]) begin qB.delete(); repeat (PD[1]) qB.push_back(idle_exp(1)); end
        if (rst[2]) begin qC.delete(); repeat (PD[2]) qC.push_back(idle_exp(2)); end
        @(negedge sysclk);
        cyc++;
        for (int k = 0; k < 3; k++)
            check(k == 0 ? "A" : (k == 1 ? "B" : "C"), "display_addr",
                  32'(dut_addr(k)), 32'({11'(mh[k]), 11'(mv[k])}));
        if (qA.size() > 0) begin
            e = qA.pop_front();
            got = dut_pins(0);
            check("A", "pins", 32'(got), 32'(e.pins));
            probe_a(e, got);
        end
        qA.push_back(model_pins(0, mh[0], mv[0]));
        if (qB.size() > 0) begin
            e = qB.pop_front();
            check("B", "pins", 32'(dut_pins(1)), 32'(e.pins));
        end
        qB.push_back(model_pins(1, mh[1], mv[1]));
        if (qC.size() > 0) begin
            e = qC.pop_front();
            got = dut_pins(2);
            check("C", "pins", 32'(got), 32'(e.pins));
            if (!rst[2]) frame_c(got);
        end
        qC.push_back(model_pins(2, mh[2], mv[2]));
    endtask

    initial begin
        int n;
        // position -> {rgb, hs, vs, fs, act} on instance A
        probes[0]  = '{0,    0,  7'b000_1110};
        probes[1]  = '{119,  0,  7'b000_1100};
        probes[2]  = '{120,  0,  7'b000_0100};
        probes[3]  = '{1039, 5,  7'b000_0100};
        probes[4]  = '{0,    6,  7'b000_1000};
        probes[5]  = '{500,  28, 7'b000_0000};
        probes[6]  = '{183,  29, 7'b000_0000};
        probes[7]  = '{184,  29, 7'b101_0001};
        probes[8]  = '{983,  29, 7'b101_0001};
        probes[9]  = '{984,  29, 7'b000_0000};
        probes[10] = '{1039, 30, 7'b000_0000};
        probes[11] = '{119,  30, 7'b000_1000};

        // reset state
        rst = 3'b111;
        repeat (3) tick();
        check("A", "reset_addr", 32'(ifA.display_addr), 32'd0);
        check("A", "reset_pins", 32'(dut_pins(0)), 32'd0);
        check("C", "reset_pins", 32'(dut_pins(2)), 32'(7'b000_1100));

        // first output cycle after release
        rst = 3'b000;
        tick();
        check("A", "first_out", 32'(dut_pins(0)), 32'(7'b000_1110));

        // mid-frame reset of B at (500,2) for two cycles
        n = 0;
        while (!(mh[1] == 500 && mv[1] == 2) && n < 5000) begin tick(); n++; end
        check("B", "reach_500_2", 32'(n < 5000), 32'd1);
        rst[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("B", "rst_addr", 32'(ifB.display_addr), 32'd0);
            check("B", "rst_pins", 32'(dut_pins(1)), 32'd0);
        end
        rst[1] = 1'b0;
        n = 0;
        while (!fsB && n < 10) begin tick(); n++; end
        check("B", "restart_latency", 32'(n), 32'd3);
        check("B", "restart_pins", 32'(dut_pins(1)), 32'(7'b000_1110));

        // scan A through line 30
        n = 0;
        while (mv[0] != 31 && n < 40000) begin tick(); n++; end
        check("A", "reach_line31", 32'(n < 40000), 32'd1);

        check("A", "probe_hits", 32'(hits), 32'd12);
        check("A", "hsync_per_line", 32'(hs29), 32'd120);
        check("A", "rgb_run", 32'(n101), 32'd800);
        check("A", "rgb_first_h", 32'(first101), 32'd184);
        check("A", "rgb_last_h", 32'(last101), 32'd983);
        check("A", "rgb_line28", 32'(nz28), 32'd0);
        check("C", "frames_seen", 32'(framesC > 3), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
